// File: rtl/reg_file_sb.sv
// Parametrised register file with same-cycle write bypass, per-register pending
// scoreboard and a post-reset clear sequencer. Optional macro: RF_ZERO_REG_EN.
module reg_file_sb #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NRD*AW-1:0]    RADDR,
    output logic [NRD*WIDTH-1:0] RDATA,
    output logic [NRD-1:0]       BUSY,
    input  logic                 WEN,
    input  logic [AW-1:0]        WADDR,
    input  logic [WIDTH-1:0]     WDATA,
    input  logic                 ISSUE,
    input  logic [AW-1:0]        ISSUE_DST,
    output logic                 READY,
    output logic                 ANY_PEND
);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    clr_ptr;
    logic [WIDTH-1:0] reg_arr [DEPTH];
    logic [DEPTH-1:0] pending;
    logic             wen_eff;
    logic             issue_eff;
    logic [AW-1:0]    rd_addr;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        if (state == ST_CLEAR && clr_ptr == AW'(DEPTH - 1)) begin
            state_next = ST_RUN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
        end
    end

    assign READY = (state == ST_RUN);

`ifdef RF_ZERO_REG_EN
    assign wen_eff   = READY && WEN && (WADDR != '0);
    assign issue_eff = READY && ISSUE && (ISSUE_DST != '0);
`else
    assign wen_eff   = READY && WEN;
    assign issue_eff = READY && ISSUE;
`endif

    // NOTE: the array has no reset branch; the clear sequencer zeroes it one entry per cycle instead.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            if (state == ST_CLEAR) begin
                reg_arr[clr_ptr] <= '0;
            end else if (wen_eff) begin
                reg_arr[WADDR] <= WDATA;
            end
        end
    end

    // Issue is applied after writeback so a same-cycle new producer leaves the bit set.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pending <= '0;
        end else begin
            if (wen_eff) begin
                pending[WADDR] <= 1'b0;
            end
            if (issue_eff) begin
                pending[ISSUE_DST] <= 1'b1;
            end
        end
    end

    assign ANY_PEND = |pending;

    always_comb begin
        RDATA   = '0;
        BUSY    = '0;
        rd_addr = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_addr = RADDR[k*AW +: AW];
            if (READY) begin
                if (wen_eff && WADDR == rd_addr) begin
                    RDATA[k*WIDTH +: WIDTH] = WDATA;
                end else begin
                    RDATA[k*WIDTH +: WIDTH] = reg_arr[rd_addr];
                    BUSY[k]                 = pending[rd_addr];
                end
`ifdef RF_ZERO_REG_EN
                if (rd_addr == '0) begin
                    RDATA[k*WIDTH +: WIDTH] = '0;
                    BUSY[k]                 = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (default parameters): per-cycle vectors
// pushed to a scoreboard queue at drive time and popped when outputs are sampled.
module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;
    logic [5:0]  raddr;
    logic [31:0] rdata;
    logic [1:0]  busy;
    logic        wen;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        issue;
    logic [2:0]  issue_dst;
    logic        ready;
    logic        any_pend;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst_n;
        logic [2:0]  ra0;
        logic [2:0]  ra1;
        logic        wen;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        iss;
        logic [2:0]  idst;
        logic        rdy;
        logic [15:0] rd0;
        logic [15:0] rd1;
        logic [1:0]  busy;
        logic        any;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[12];

    reg_file_sb dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .RADDR    (raddr),
        .RDATA    (rdata),
        .BUSY     (busy),
        .WEN      (wen),
        .WADDR    (waddr),
        .WDATA    (wdata),
        .ISSUE    (issue),
        .ISSUE_DST(issue_dst),
        .READY    (ready),
        .ANY_PEND (any_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [2:0] ra0, input logic [2:0] ra1,
                                input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                input logic is, input logic [2:0] idst, input logic rdy,
                                input logic [15:0] rd0, input logic [15:0] rd1,
                                input logic [1:0] bz, input logic an);
        vec_t v;
        v.rst_n = r;   v.ra0 = ra0;  v.ra1 = ra1;
        v.wen   = we;  v.wa  = wa;   v.wd  = wd;
        v.iss   = is;  v.idst = idst;
        v.rdy   = rdy; v.rd0 = rd0;  v.rd1 = rd1;
        v.busy  = bz;  v.any = an;
        return v;
    endfunction

    // Called at a negedge: drive, sample 1 ns later, then advance one full cycle.
    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        rst_n     = v.rst_n;
        raddr     = {v.ra1, v.ra0};
        wen       = v.wen;
        waddr     = v.wa;
        wdata     = v.wd;
        issue     = v.iss;
        issue_dst = v.idst;
        exp_q.push_back(v);
        #1;
        e = exp_q.pop_front();
        check({tag, " ready"}, 16'(ready), 16'(e.rdy));
        check({tag, " rdata0"}, rdata[15:0], e.rd0);
        check({tag, " rdata1"}, rdata[31:16], e.rd1);
        check({tag, " busy"}, 16'(busy), 16'(e.busy));
        check({tag, " any_pend"}, 16'(any_pend), 16'(e.any));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0;
        issue = 1'b0; issue_dst = '0;

        tbl[0]  = mk(1, 3, 4, 1, 3, 16'hBEEF, 0, 0, 1, 16'hBEEF, 16'h0000, 2'b00, 0);
        tbl[1]  = mk(1, 3, 3, 0, 0, 16'h0000, 0, 0, 1, 16'hBEEF, 16'hBEEF, 2'b00, 0);
        tbl[2]  = mk(1, 5, 3, 0, 0, 16'h0000, 1, 5, 1, 16'h0000, 16'hBEEF, 2'b00, 0);
        tbl[3]  = mk(1, 5, 5, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 2'b11, 1);
        tbl[4]  = mk(1, 5, 3, 1, 5, 16'h1234, 0, 0, 1, 16'h1234, 16'hBEEF, 2'b00, 1);
        tbl[5]  = mk(1, 5, 5, 0, 0, 16'h0000, 0, 0, 1, 16'h1234, 16'h1234, 2'b00, 0);
        tbl[6]  = mk(1, 2, 5, 1, 2, 16'h00AA, 1, 2, 1, 16'h00AA, 16'h1234, 2'b00, 0);
        tbl[7]  = mk(1, 2, 2, 0, 0, 16'h0000, 0, 0, 1, 16'h00AA, 16'h00AA, 2'b11, 1);
`ifdef RF_ZERO_REG_EN
        tbl[8]  = mk(1, 0, 2, 1, 0, 16'h5555, 1, 0, 1, 16'h0000, 16'h00AA, 2'b10, 1);
        tbl[9]  = mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 2'b00, 1);
`else
        tbl[8]  = mk(1, 0, 2, 1, 0, 16'h5555, 1, 0, 1, 16'h5555, 16'h00AA, 2'b10, 1);
        tbl[9]  = mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h5555, 16'h5555, 2'b11, 1);
`endif
        tbl[10] = mk(1, 7, 6, 1, 7, 16'hFFFF, 0, 0, 1, 16'hFFFF, 16'h0000, 2'b00, 1);
        tbl[11] = mk(1, 7, 2, 0, 0, 16'h0000, 0, 0, 1, 16'hFFFF, 16'h00AA, 2'b10, 1);

        // Power-on reset, then the clear sequence must take exactly eight edges.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        run_vec(mk(0, 0, 1, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 2'b00, 0), "reset");
        for (int i = 0; i < 8; i++) begin
            run_vec(mk(1, 3'(i), 3'(7 - i), 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 2'b00, 0),
                    $sformatf("clear%0d", i));
        end
        for (int a = 0; a < 8; a++) begin
            run_vec(mk(1, 3'(a), 3'(a), 0, 0, 16'h0, 0, 0, 1, 16'h0, 16'h0, 2'b00, 0),
                    $sformatf("zeroed%0d", a));
        end

        for (int i = 0; i < 12; i++) begin
            run_vec(tbl[i], $sformatf("tbl%0d", i));
        end

        // Mid-run reset pulse; writes and issues held active through the clear are ignored.
        run_vec(mk(0, 7, 2, 0, 0, 16'h0, 0, 0, 1, 16'hFFFF, 16'h00AA, 2'b10, 1), "midrun_rst");
        for (int i = 0; i < 8; i++) begin
            run_vec(mk(1, 7, 4, 1, 7, 16'hABCD, 1, 4, 0, 16'h0, 16'h0, 2'b00, 0),
                    $sformatf("reclear%0d", i));
        end
        run_vec(mk(1, 7, 4, 0, 0, 16'h0, 0, 0, 1, 16'h0, 16'h0, 2'b00, 0), "after_reclear");
        run_vec(mk(1, 3, 2, 0, 0, 16'h0, 0, 0, 1, 16'h0, 16'h0, 2'b00, 0), "after_reclear2");

        // Reset landing mid-clear must restart the count from zero.
        run_vec(mk(0, 1, 2, 0, 0, 16'h0, 0, 0, 1, 16'h0, 16'h0, 2'b00, 0), "rst_a");
        for (int i = 0; i < 3; i++) begin
            run_vec(mk(1, 1, 2, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 2'b00, 0),
                    $sformatf("partial%0d", i));
        end
        run_vec(mk(0, 1, 2, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 2'b00, 0), "rst_b");
        for (int i = 0; i < 8; i++) begin
            run_vec(mk(1, 1, 2, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 2'b00, 0),
                    $sformatf("restart%0d", i));
        end
        run_vec(mk(1, 1, 2, 0, 0, 16'h0, 0, 0, 1, 16'h0, 16'h0, 2'b00, 0), "restart_done");

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised general-purpose register file for the 16-b RISC datapath, the successor to the fixed 8x16 two-read/one-write file. It adds a configurable number of read ports, same-cycle write-to-read bypass, a per-register pending (scoreboard) bit for in-flight results, and a synchronous clear sequencer that zeroes the array after reset. It sits between decode (read addresses, issue) and writeback (write port).

## Interface

- WIDTH, 16, data width of each register
- DEPTH, 8, number of registers (power of two, >= 2)
- NRD, 2, number of read ports (>= 1)
- AW, $clog2(DEPTH), address width (derived; not overridden)

Ports:

- CLK  input  1  clock; all state updates on posedge
- RST_N  input  1  reset, synchronous, active-low
- RADDR  input  NRD*AW  read addresses; port k = RADDR[k*AW +: AW]
- RDATA  output  NRD*WIDTH  read data; port k = RDATA[k*WIDTH +: WIDTH]
- BUSY  output  NRD  BUSY[k] = register at read port k has a pending result
- WEN  input  1  write enable
- WADDR  input  AW  write address
- WDATA  input  WIDTH  write data
- ISSUE  input  1  mark ISSUE_DST pending (instruction issued with that destination)
- ISSUE_DST  input  AW  destination being issued
- READY  output  1  clear done; file accepts writes/issues
- ANY_PEND  output  1  OR of all pending bits

## Operation

- States: CLEAR, RUN. RST_N low at a posedge: state <= CLEAR, clr_ptr <= 0, all pending bits <= 0, READY <= 0.
- CLEAR (RST_N high): each cycle write 0 to regARR[clr_ptr], clr_ptr++; on the edge writing DEPTH-1 go to RUN and set READY <= 1.
- RUN: on WEN, regARR[WADDR] <= WDATA and pending[WADDR] <= 0. On ISSUE, pending[ISSUE_DST] <= 1.
- Same address written and issued in one cycle: data is written, pending ends 1 (new producer wins).
- WEN/ISSUE while READY=0: ignored entirely.
- Read port k (combinational): if READY=0, RDATA[k]=0, BUSY[k]=0. Else if WEN and WADDR==RADDR[k], RDATA[k]=WDATA (bypass) and BUSY[k]=0; else RDATA[k]=regARR[RADDR[k]], BUSY[k]=pending[RADDR[k]].
- Multiple ports may read the same address; all return identical data.
- ANY_PEND registered-state derived: OR of pending, combinational from the pending vector.

## Timing

- Reset values: READY=0, RDATA=0, BUSY=0, ANY_PEND=0.
- Clear latency: READY rises after exactly DEPTH posedges with RST_N high (8 for defaults). RST_N low mid-clear or mid-run restarts from clr_ptr=0.
- Write latency: visible via array one cycle after WEN edge; same cycle via bypass.
- Issue latency: BUSY for that address rises the cycle after the ISSUE edge.
- No stalls/backpressure; one write and one issue per cycle maximum.

## Configuration

- RF_ZERO_REG_EN defined: register 0 hardwired zero. Writes to address 0 dropped, ISSUE to 0 ignored, reads of 0 return 0 with BUSY=0 (bypass not applied to address 0), even when WEN hits address 0.
- Undefined: register 0 is an ordinary register, identical to all others.

## Test plan

- Reset then release: RDATA=0, READY=0 for 8 cycles, READY=1 on cycle 8; all registers read 0 on every port.
- WEN, WADDR=3, WDATA=16'hBEEF with RADDR port0=3: port0 reads 16'hBEEF same cycle (bypass) and next cycle (array); port1 reading 4 returns 0.
- ISSUE_DST=5, next cycle RADDR=5 -> BUSY=1, ANY_PEND=1; WEN to 5 with 16'h1234 -> BUSY=0 same cycle, RDATA=16'h1234; ANY_PEND=0 next cycle.
- Same cycle ISSUE_DST=2 and WEN WADDR=2 WDATA=16'h00AA -> next cycle reads 16'h00AA with BUSY=1.
- Write 16'hFFFF to 7, pulse RST_N low one cycle mid-run, WEN during CLEAR -> ignored; after READY register 7 reads 0, no BUSY.
- With RF_ZERO_REG_EN: write 16'h5555 to 0 and issue 0 -> reads 0, BUSY=0; without it reads 16'h5555.
